// File: rtl/alu_decode_stage.sv
// RV32I decode stage: turns an instruction into ALU operands/op code behind a valid/ready handshake.
// Define ALU_DECODE_SKID_EN for a two-entry skid buffer with registered InReady.
module alu_decode_stage #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [31:0]              Instr,
    input  logic [DATA_WIDTH-1:0]    PC,
    input  logic [DATA_WIDTH-1:0]    RegA,
    input  logic [DATA_WIDTH-1:0]    RegB,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     BranchInvert,
    output logic                     IllegalInstr
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpOr   = 4'b0001;
    localparam logic [3:0] OpAdd  = 4'b0010;
    localparam logic [3:0] OpXor  = 4'b0011;
    localparam logic [3:0] OpSll  = 4'b0100;
    localparam logic [3:0] OpSrl  = 4'b0101;
    localparam logic [3:0] OpSub  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpBeq  = 4'b1000;
    localparam logic [3:0] OpBne  = 4'b1001;
    localparam logic [3:0] OpJump = 4'b1010;
    localparam logic [3:0] OpIll  = 4'b1011;
    localparam logic [3:0] OpSlt  = 4'b1100;
    localparam logic [3:0] OpSltu = 4'b1110;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] srca;
        logic [DATA_WIDTH-1:0] srcb;
        logic [3:0]            op;
        logic                  binv;
        logic                  ill;
    } entry_t;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic                  is_r;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [3:0]            alu_op;
    logic                  alu_ok;
    logic                  illegal;
    entry_t                dec;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];
    assign is_r   = (opcode == OpcOp);
    assign imm_i  = DATA_WIDTH'($signed(Instr[31:20]));
    assign imm_s  = DATA_WIDTH'($signed({Instr[31:25], Instr[11:7]}));
    assign imm_u  = DATA_WIDTH'($signed({Instr[31:12], 12'b0}));

    // Shared R/I arithmetic decode; funct7 only matters for R-type except on shifts.
    always_comb begin
        alu_op = OpAdd;
        alu_ok = 1'b1;
        unique case (funct3)
            3'b000: begin
                alu_op = (is_r && funct7 == F7Alt) ? OpSub : OpAdd;
                alu_ok = !is_r || funct7 == F7Zero || funct7 == F7Alt;
            end
            3'b001: begin
                alu_op = OpSll;
                alu_ok = (funct7 == F7Zero);
            end
            3'b010: begin
                alu_op = OpSlt;
                alu_ok = !is_r || funct7 == F7Zero;
            end
            3'b011: begin
                alu_op = OpSltu;
                alu_ok = !is_r || funct7 == F7Zero;
            end
            3'b100: begin
                alu_op = OpXor;
                alu_ok = !is_r || funct7 == F7Zero;
            end
            3'b101: begin
                alu_op = Instr[30] ? OpSra : OpSrl;
                alu_ok = (funct7 == F7Zero) || (funct7 == F7Alt);
            end
            3'b110: begin
                alu_op = OpOr;
                alu_ok = !is_r || funct7 == F7Zero;
            end
            3'b111: begin
                alu_op = OpAnd;
                alu_ok = !is_r || funct7 == F7Zero;
            end
        endcase
    end

    always_comb begin
        dec     = '0;
        dec.op  = OpAdd;
        illegal = 1'b0;
        case (opcode)
            OpcOp: begin
                dec.srca = RegA;
                dec.srcb = RegB;
                dec.op   = alu_op;
                illegal  = !alu_ok;
            end
            OpcOpImm: begin
                dec.srca = RegA;
                dec.srcb = imm_i;
                dec.op   = alu_op;
                illegal  = !alu_ok;
            end
            OpcBranch: begin
                dec.srca = RegA;
                dec.srcb = RegB;
                case (funct3)
                    3'b000:  dec.op = OpBeq;
                    3'b001:  dec.op = OpBne;
                    3'b100:  dec.op = OpSlt;
                    3'b101: begin
                        dec.op   = OpSlt;
                        dec.binv = 1'b1;
                    end
                    3'b110:  dec.op = OpSltu;
                    3'b111: begin
                        dec.op   = OpSltu;
                        dec.binv = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OpcLoad: begin
                dec.srca = RegA;
                dec.srcb = imm_i;
            end
            OpcStore: begin
                dec.srca = RegA;
                dec.srcb = imm_s;
            end
            OpcLui: begin
                dec.srcb = imm_u;
            end
            OpcAuipc: begin
                dec.srca = PC;
                dec.srcb = imm_u;
            end
            OpcJal, OpcJalr: begin
                dec.srca = PC;
                dec.srcb = DATA_WIDTH'(4);
                dec.op   = OpJump;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec     = '0;
            dec.op  = OpIll;
            dec.ill = 1'b1;
        end
    end

    logic   in_xfer;
    logic   out_valid_q, out_valid_d;
    entry_t out_q, out_d;

    assign in_xfer = InValid && InReady;

`ifdef ALU_DECODE_SKID_EN
    logic   skid_valid_q, skid_valid_d;
    entry_t skid_q, skid_d;
    logic   ready_q, ready_d;

    assign InReady = ready_q;

    // Output slot refills from the skid entry first so ordering is preserved.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || OutReady) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_xfer;
                if (in_xfer) out_d = dec;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_d       = dec;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            ready_q      <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            ready_q      <= ready_d;
        end
    end
`else
    assign InReady = !out_valid_q || OutReady;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (InReady) begin
            out_valid_d = in_xfer;
            if (in_xfer) out_d = dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end
`endif

    assign OutValid     = out_valid_q;
    assign SrcA         = out_q.srca;
    assign SrcB         = out_q.srcb;
    assign Operation    = OPCODE_LENGTH'(out_q.op);
    assign BranchInvert = out_q.binv;
    assign IllegalInstr = out_q.ill;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed scoreboard bench for alu_decode_stage; handles both buffering modes.
module tb_alu_decode_stage;

`ifdef ALU_DECODE_SKID_EN
    localparam bit Skid = 1'b1;
`else
    localparam bit Skid = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [3:0]  op;
        logic        binv;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        InValid, InReady, OutValid, OutReady;
    logic [31:0] Instr, PC, RegA, RegB, SrcA, SrcB;
    logic [3:0]  Operation;
    logic        BranchInvert, IllegalInstr;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_decode_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .InValid(InValid), .InReady(InReady), .Instr(Instr), .PC(PC),
        .RegA(RegA), .RegB(RegB),
        .OutValid(OutValid), .OutReady(OutReady), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .BranchInvert(BranchInvert), .IllegalInstr(IllegalInstr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] sa, input logic [31:0] sb,
                                input logic [3:0] op, input logic binv, input logic ill);
        exp_t e;
        e.srca = sa;
        e.srcb = sb;
        e.op   = op;
        e.binv = binv;
        e.ill  = ill;
        return e;
    endfunction

    // Holds InValid until accepted; expected result queued at the accepting edge.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input bit lat_chk);
        bit acc = 1'b0;
        Instr   = instr;
        PC      = pc;
        RegA    = a;
        RegB    = b;
        InValid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = InReady;
            @(posedge clk);
            if (acc) sbq.push_back(e);
        end
        #1;
        InValid = 1'b0;
        check("send_accepted", {63'b0, acc}, 64'd1);
        if (lat_chk) check("latency_outvalid", {63'b0, OutValid}, 64'd1);
    endtask

    // Output monitor: compares the head entry every valid cycle, pops on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && OutValid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("spurious_out", {63'b0, OutValid}, 64'd0);
            end else begin
                e = sbq[0];
                check("srca", {32'b0, SrcA}, {32'b0, e.srca});
                check("srcb", {32'b0, SrcB}, {32'b0, e.srcb});
                check("operation", {60'b0, Operation}, {60'b0, e.op});
                check("branch_invert", {63'b0, BranchInvert}, {63'b0, e.binv});
                check("illegal", {63'b0, IllegalInstr}, {63'b0, e.ill});
                if (OutReady) e = sbq.pop_front();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        Instr    = '0;
        PC       = '0;
        RegA     = '0;
        RegB     = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_outvalid", {63'b0, OutValid}, 64'd0);
        check("rst_srca", {32'b0, SrcA}, 64'd0);
        check("rst_srcb", {32'b0, SrcB}, 64'd0);
        check("rst_operation", {60'b0, Operation}, 64'd0);
        check("rst_binv", {63'b0, BranchInvert}, 64'd0);
        check("rst_illegal", {63'b0, IllegalInstr}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("inready_after_release", {63'b0, InReady}, 64'd1);

        // Single transfers with the downstream always ready.
        send(32'h003100B3, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b0010, 1'b0, 1'b0), 1'b1);
        send(32'h403100B3, 32'h0, 32'd9, 32'd4, mk(32'd9, 32'd4, 4'b0110, 1'b0, 1'b0), 1'b1);
        send(32'hFFF10093, 32'h0, 32'd3, 32'd8, mk(32'd3, 32'hFFFFFFFF, 4'b0010, 1'b0, 1'b0), 1'b1);
        send(32'h123450B7, 32'h40, 32'h55, 32'h66, mk(32'd0, 32'h12345000, 4'b0010, 1'b0, 1'b0), 1'b1);
        send(32'h0020D463, 32'h0, 32'd1, 32'd2, mk(32'd1, 32'd2, 4'b1100, 1'b1, 1'b0), 1'b1);
        send(32'h0000007F, 32'h10, 32'd11, 32'd12, mk(32'd0, 32'd0, 4'b1011, 1'b0, 1'b1), 1'b1);
        send(32'h00208463, 32'h0, 32'd4, 32'd4, mk(32'd4, 32'd4, 4'b1000, 1'b0, 1'b0), 1'b1);
        send(32'h0020E463, 32'h0, 32'd6, 32'd3, mk(32'd6, 32'd3, 4'b1110, 1'b0, 1'b0), 1'b1);
        send(32'h00001097, 32'h100, 32'd1, 32'd1, mk(32'h100, 32'h1000, 4'b0010, 1'b0, 1'b0), 1'b1);
        send(32'h008000EF, 32'h200, 32'd1, 32'd1, mk(32'h200, 32'd4, 4'b1010, 1'b0, 1'b0), 1'b1);
        send(32'h4020D093, 32'h0, 32'hF0, 32'd0, mk(32'hF0, 32'h402, 4'b0111, 1'b0, 1'b0), 1'b1);
        send(32'h0020B0B3, 32'h0, 32'd2, 32'd9, mk(32'd2, 32'd9, 4'b1110, 1'b0, 1'b0), 1'b1);
        send(32'h00112423, 32'h0, 32'h80, 32'h77, mk(32'h80, 32'd8, 4'b0010, 1'b0, 1'b0), 1'b1);
        send(32'h203100B3, 32'h0, 32'd5, 32'd7, mk(32'd0, 32'd0, 4'b1011, 1'b0, 1'b1), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("drain_basic", sbq.size(), 64'd0);

        // Backpressure: four back-to-back with OutReady low for three edges.
        OutReady = 1'b0;
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    send(32'h003100B3, 32'h0, k, 32'd10 * k,
                         mk(k, 32'd10 * k, 4'b0010, 1'b0, 1'b0), 1'b0);
                end
            end
            begin
                @(posedge clk);
                #2;
                check("bp_inready_one_held", {63'b0, InReady}, {63'b0, Skid});
                @(posedge clk);
                #2;
                check("bp_inready_two_held", {63'b0, InReady}, 64'd0);
                @(posedge clk);
                #1 OutReady = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("bp_drained", sbq.size(), 64'd0);

        // OutReady toggling every cycle while a burst streams in.
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send(32'h0020B0B3, 32'h0, 32'd100 + k, 32'd7,
                         mk(32'd100 + k, 32'd7, 4'b1110, 1'b0, 1'b0), 1'b0);
                end
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(posedge clk);
                    #1 OutReady = ~OutReady;
                end
                OutReady = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("toggle_drained", sbq.size(), 64'd0);

        // Reset with a held instruction: it must vanish.
        OutReady = 1'b0;
        send(32'h0020D463, 32'h0, 32'd5, 32'd7, mk(32'd5, 32'd7, 4'b1100, 1'b1, 1'b0), 1'b0);
        check("rst_pre_valid", {63'b0, OutValid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outvalid", {63'b0, OutValid}, 64'd0);
        check("rst_async_srca", {32'b0, SrcA}, 64'd0);
        check("rst_async_operation", {60'b0, Operation}, 64'd0);
        check("rst_async_binv", {63'b0, BranchInvert}, 64'd0);
        sbq.delete();
        @(negedge clk);
        #1;
        OutReady = 1'b1;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_inready", {63'b0, InReady}, 64'd1);
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_output", {63'b0, OutValid}, 64'd0);
        check("final_scoreboard_empty", sbq.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
